// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-lane mask helper for the data memory.
// The CLEAR state exists only when DMEM_ZERO_INIT_EN is defined.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

`ifdef DMEM_ZERO_INIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2, ST_CLEAR = 2'd3} dmem_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} dmem_state_t;
`endif

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << lo;
      SZ_HALF: byte_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 sub-word accesses: store lane replication,
// load shift plus sign/zero extension, and alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_word,
  input  logic [31:0] store_data,
  output logic [3:0]  mask,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        misalign
);

  logic [31:0] shifted_s;

  assign mask = byte_mask(size, addr_lo);

  // Load extension, store replication (the mask picks the live lanes) and alignment
  always_comb begin
    shifted_s  = raw_word >> {addr_lo, 3'b000};
    load_value = 32'd0;
    store_word = 32'd0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        load_value = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
        store_word = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        load_value = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
        store_word = {2{store_data[15:0]}};
        misalign   = addr_lo[0];
      end
      SZ_WORD: begin
        load_value = raw_word;
        store_word = store_data;
        misalign   = (addr_lo != 2'b00);
      end
      default: begin
        load_value = 32'd0;
        store_word = 32'd0;
        misalign   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ext.sv
// Word-organised data memory with request/response handshake and programmable latency.
// Optional DMEM_ZERO_INIT_EN adds a post-reset zero-fill sweep before accepting requests.
module data_memory_ext
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH   = 16384,
  parameter int LATENCY     = 1,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [7:0] LAT_C = 8'(LATENCY);

  logic [31:0] mem_r [MEM_DEPTH];

  dmem_state_t state_r;
  logic [7:0]  cnt_r;
  logic        write_r;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] wdata_r;
`ifdef DMEM_ZERO_INIT_EN
  logic [AW-1:0] clr_idx_r;
`endif

  logic [AW-1:0] idx_s;
  logic [3:0]    mask_s;
  logic [31:0]   st_word_s;
  logic [31:0]   ld_val_s;
  logic          misalign_s;
  logic          range_err_s;
  logic          err_s;
  logic          last_wait_s;
  logic          commit_s;

  assign idx_s = addr_r[AW+1:2];

  dmem_lane_align u_align (
    .size       (size_r),
    .is_unsigned(uns_r),
    .addr_lo    (addr_r[1:0]),
    .raw_word   (mem_r[idx_s]),
    .store_data (wdata_r),
    .mask       (mask_s),
    .store_word (st_word_s),
    .load_value (ld_val_s),
    .misalign   (misalign_s)
  );

  // Out-of-range detection on address bits above the word index
  always_comb begin
    if (CHECK_RANGE != 0) begin
      range_err_s = ((addr_r >> (AW + 2)) != 32'd0);
    end else begin
      range_err_s = 1'b0;
    end
  end

  assign err_s       = misalign_s | (size_r == SZ_ILL) | range_err_s;
  assign last_wait_s = (state_r == ST_WAIT) && (cnt_r == LAT_C);
  assign commit_s    = last_wait_s && write_r && !err_s;

  // Memory array port: zero-fill sweep or masked store commit on the edge entering RESP
  always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
    if ((state_r == ST_CLEAR) && !reset) begin
      mem_r[clr_idx_r] <= 32'd0;
    end else
`endif
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) mem_r[idx_s][8*i +: 8] <= st_word_s[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef DMEM_ZERO_INIT_EN
      state_r   <= ST_CLEAR;
      req_ready <= 1'b0;
      clr_idx_r <= '0;
`else
      state_r   <= ST_IDLE;
      req_ready <= 1'b1;
`endif
      cnt_r      <= 8'd0;
      write_r    <= 1'b0;
      addr_r     <= 32'd0;
      size_r     <= SZ_BYTE;
      uns_r      <= 1'b0;
      wdata_r    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            write_r   <= req_write;
            addr_r    <= req_addr;
            size_r    <= req_size;
            uns_r     <= req_unsigned;
            wdata_r   <= req_wdata;
            cnt_r     <= 8'd0;
            req_ready <= 1'b0;
            state_r   <= ST_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        // cnt_r walks 1..LATENCY; the response is loaded on the following edge
        ST_WAIT: begin
          if (last_wait_s) begin
            state_r    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_s;
            resp_rdata <= (err_s || write_r) ? 32'd0 : ld_val_s;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          state_r    <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          cnt_r      <= 8'd0;
        end
`ifdef DMEM_ZERO_INIT_EN
        ST_CLEAR: begin
          if (&clr_idx_r) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            clr_idx_r <= clr_idx_r + 1'b1;
          end
        end
`endif
        default: begin
          state_r    <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ext.sv
// Randomized and directed bench for data_memory_ext against a word-array reference model.
module tb_data_memory_ext;
  import dmem_pkg::*;

  localparam int DEPTH = 16384;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;
  bit [31:0] model [int];

  always #5 clk = ~clk;

  data_memory_ext #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .CHECK_RANGE(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed RV32 load/store semantics over a sparse word array
  task automatic model_access(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                              input logic u, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd);
    logic [31:0] w, v;
    int sh, k;
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
          || (a >= 32'(DEPTH * 4));
    rd = 32'd0;
    if (err) return;
    k  = int'(a / 4);
    w  = model.exists(k) ? model[k] : 32'd0;
    sh = int'(a % 4) * 8;
    if (wr) begin
      if (sz == 2'd0)      w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else if (sz == 2'd1) w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      else                 w = wd;
      model[k] = w;
    end else begin
      if (sz == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
        v = w;
      end
      rd = v;
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input string tag);
    int n;
    bit seen, busy_ok;
    logic exp_err;
    logic [31:0] exp_rd, got_rd;
    logic got_err, got_rdy;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_value({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
    model_access(wr, a, sz, u, wd, exp_err, exp_rd);
    n = 0; seen = 1'b0; busy_ok = 1'b1; got_rd = 32'd0; got_err = 1'b0; got_rdy = 1'b0;
    while (!seen && n < LAT + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) begin
        seen = 1'b1; got_rd = resp_rdata; got_err = resp_err; got_rdy = req_ready;
      end else if (req_ready) begin
        busy_ok = 1'b0;
      end
    end
    check_value({tag, " latency"}, 32'(n), 32'(LAT + 1));
    check_value({tag, " busy"}, 32'({busy_ok, got_rdy}), 32'b10);
    check_value({tag, " err"}, 32'(got_err), 32'(exp_err));
    check_value({tag, " rdata"}, got_rd, exp_rd);
    @(posedge clk);
    #1;
    check_value({tag, " pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (!req_ready && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value({tag, " clear_cycles"}, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int q;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
`ifdef DMEM_ZERO_INIT_EN
    check_value("reset req_ready", 32'(req_ready), 32'd0);
`else
    check_value("reset req_ready", 32'(req_ready), 32'd1);
`endif
    check_value("reset resp_valid", 32'(resp_valid), 32'd0);
    check_value("reset resp_rdata", resp_rdata, 32'd0);
    check_value("reset resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`ifdef DMEM_ZERO_INIT_EN
    wait_ready("init", DEPTH + 10);
    do_req(1'b0, 32'h0000_0000, SZ_WORD, 1'b0, 32'd0, "clr lw0");
    do_req(1'b0, 32'((DEPTH - 1) * 4), SZ_WORD, 1'b0, 32'd0, "clr lwlast");
`endif

    do_req(1'b1, 32'h100, SZ_WORD, 1'b0, 32'hDEAD_BEEF, "sw100");
    do_req(1'b0, 32'h100, SZ_WORD, 1'b0, 32'd0, "lw100");

    do_req(1'b1, 32'h40, SZ_WORD, 1'b0, 32'h1122_3344, "sw40");
    do_req(1'b1, 32'h41, SZ_BYTE, 1'b0, 32'h1234_56AA, "sb41");
    do_req(1'b0, 32'h41, SZ_BYTE, 1'b0, 32'd0, "lb41");
    do_req(1'b0, 32'h41, SZ_BYTE, 1'b1, 32'd0, "lbu41");
    do_req(1'b0, 32'h40, SZ_WORD, 1'b1, 32'd0, "lw40a");
    do_req(1'b1, 32'h42, SZ_HALF, 1'b0, 32'h5A5A_8001, "sh42");
    do_req(1'b0, 32'h42, SZ_HALF, 1'b0, 32'd0, "lh42");
    do_req(1'b0, 32'h42, SZ_HALF, 1'b1, 32'd0, "lhu42");
    do_req(1'b0, 32'h40, SZ_WORD, 1'b0, 32'd0, "lw40b");

    do_req(1'b1, 32'h103, SZ_WORD, 1'b0, 32'h0BAD_0BAD, "sw103 err");
    do_req(1'b0, 32'h101, SZ_HALF, 1'b0, 32'd0, "lh101 err");
    do_req(1'b0, 32'h100, SZ_ILL, 1'b0, 32'd0, "size3 err");
    do_req(1'b0, 32'h0001_0000, SZ_WORD, 1'b0, 32'd0, "range err");
    do_req(1'b1, 32'h0001_0100, SZ_WORD, 1'b0, 32'hFFFF_FFFF, "sw range err");
    do_req(1'b0, 32'h100, SZ_WORD, 1'b0, 32'd0, "lw100 after err");

    // Abort a store in WAIT with an asynchronous reset
    do_req(1'b1, 32'h200, SZ_WORD, 1'b0, 32'h5A5A_5A5A, "sw200 old");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_size = SZ_WORD;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
`ifdef DMEM_ZERO_INIT_EN
    check_value("abort req_ready", 32'(req_ready), 32'd0);
`else
    check_value("abort req_ready", 32'(req_ready), 32'd1);
`endif
    check_value("abort resp_valid", 32'(resp_valid), 32'd0);
    check_value("abort resp_rdata", resp_rdata, 32'd0);
    check_value("abort resp_err", 32'(resp_err), 32'd0);
    q = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (resp_valid) q++;
    end
    @(negedge clk);
    reset = 1'b0;
`ifdef DMEM_ZERO_INIT_EN
    model.delete();
    wait_ready("reinit", DEPTH + 10);
`else
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid) q++;
    end
`endif
    check_value("abort no resp", 32'(q), 32'd0);
    do_req(1'b0, 32'h200, SZ_WORD, 1'b0, 32'd0, "lw200 after abort");

    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 32'h300 + 32'(i * 4), SZ_WORD, 1'b0, $urandom, "rnd init");
    end
    for (int i = 0; i < 60; i++) begin
      a = 32'h300 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | 32'h0002_0000;
      do_req(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
